// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, imem req/rdy handshake and the IF/ID register.
// It parks a fetched word during decode stalls and drains a stale response after a redirect.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold_pc,
  input  logic        hold_ifid,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_ID_Instr,
  output logic [31:0] IF_ID_PC4,
  output logic        IF_ID_Valid
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic [31:0] park_instr, park_instr_nxt;
  logic [31:0] park_pc4, park_pc4_nxt;
  logic [31:0] instr_nxt, pc4_nxt;
  logic        valid_nxt;
  logic [31:0] pc_plus4;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

  assign pc_plus4 = pc + 32'd4;

  // The reset gate keeps the request low while rst_n is held, even though state resets to FETCH.
  assign imem_req  = rst_n && (state == FETCH);
  assign imem_addr = pc;

  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    park_instr_nxt = park_instr;
    park_pc4_nxt   = park_pc4;
    instr_nxt      = IF_ID_Instr;
    pc4_nxt        = IF_ID_PC4;
    valid_nxt      = IF_ID_Valid;

    if (branch_taken) begin
      pc_nxt         = word_align(branch_target);
      instr_nxt      = 32'd0;
      valid_nxt      = 1'b0;
      park_instr_nxt = 32'd0;
      park_pc4_nxt   = 32'd0;
      // A request still in flight will answer later; its response must be swallowed.
      if ((state == FETCH || state == DRAIN) && !imem_rdy)
        state_nxt = DRAIN;
      else
        state_nxt = FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_rdy) begin
            if (hold_ifid) begin
              park_instr_nxt = imem_rdata;
              park_pc4_nxt   = pc_plus4;
              state_nxt      = HOLD;
            end else begin
              instr_nxt = imem_rdata;
              pc4_nxt   = pc_plus4;
              valid_nxt = 1'b1;
              if (!hold_pc)
                pc_nxt = pc_plus4;
            end
          end else if (!hold_ifid) begin
            instr_nxt = 32'd0;
            valid_nxt = 1'b0;
          end
        end
        HOLD: begin
          if (!hold_ifid) begin
            instr_nxt = park_instr;
            pc4_nxt   = park_pc4;
            valid_nxt = 1'b1;
            state_nxt = FETCH;
            if (!hold_pc)
              pc_nxt = park_pc4;
          end
        end
        DRAIN: begin
          if (imem_rdy)
            state_nxt = FETCH;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  // Stage boundary: PC, park buffer and IF/ID register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FETCH;
      pc          <= word_align(RESET_PC);
      park_instr  <= 32'd0;
      park_pc4    <= 32'd0;
      IF_ID_Instr <= 32'd0;
      IF_ID_PC4   <= 32'd0;
      IF_ID_Valid <= 1'b0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      park_instr  <= park_instr_nxt;
      park_pc4    <= park_pc4_nxt;
      IF_ID_Instr <= instr_nxt;
      IF_ID_PC4   <= pc4_nxt;
      IF_ID_Valid <= valid_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold_pc;
  logic        hold_ifid;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy;
  logic [31:0] imem_rdata;
  logic [31:0] IF_ID_Instr;
  logic [31:0] IF_ID_PC4;
  logic        IF_ID_Valid;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(32'h0000_0040)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .hold_pc      (hold_pc),
    .hold_ifid    (hold_ifid),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdy     (imem_rdy),
    .imem_rdata   (imem_rdata),
    .IF_ID_Instr  (IF_ID_Instr),
    .IF_ID_PC4    (IF_ID_PC4),
    .IF_ID_Valid  (IF_ID_Valid)
  );

  // Instruction memory contents: a recognisable, never-zero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign imem_rdata = imem_rdy ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  typedef struct {
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        chk_pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      n_vec++;
      if ((imem_req !== e.req) || (imem_addr !== e.addr) || (IF_ID_Valid !== e.valid) ||
          (IF_ID_Instr !== e.instr) || (e.chk_pc4 && (IF_ID_PC4 !== e.pc4))) begin
        n_bad++;
        $display("FAIL vec%0d: got req=%b addr=%h valid=%b instr=%h pc4=%h, want req=%b addr=%h valid=%b instr=%h pc4=%h",
                 n_vec, imem_req, imem_addr, IF_ID_Valid, IF_ID_Instr, IF_ID_PC4,
                 e.req, e.addr, e.valid, e.instr, e.chk_pc4 ? e.pc4 : IF_ID_PC4);
      end
    end
  end

  task automatic push_exp(input logic req, input logic [31:0] addr, input logic valid,
                          input logic [31:0] instr, input logic [31:0] pc4, input logic chk);
    exp_t e;
    e.req = req; e.addr = addr; e.valid = valid;
    e.instr = instr; e.pc4 = pc4; e.chk_pc4 = chk;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, then queue what the DUT must show after the edge.
  // e_ia is the address whose instruction IF/ID must hold when e_valid is set.
  task automatic cyc(input logic rdy, input logic hp, input logic hi,
                     input logic br, input logic [31:0] tgt,
                     input logic e_req, input logic [31:0] e_addr,
                     input logic e_valid, input logic [31:0] e_ia);
    imem_rdy      = rdy;
    hold_pc       = hp;
    hold_ifid     = hi;
    branch_taken  = br;
    branch_target = tgt;
    @(posedge clk);
    #1;
    if (e_valid)
      push_exp(e_req, e_addr, 1'b1, mem_word(e_ia), e_ia + 32'd4, 1'b1);
    else
      push_exp(e_req, e_addr, 1'b0, 32'd0, 32'd0, 1'b0);
    @(negedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required<100000", $time);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; hold_pc = 1'b0; hold_ifid = 1'b0;
    branch_taken = 1'b0; branch_target = 32'd0; imem_rdy = 1'b0;
    push_exp(1'b0, 32'h40, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Zero-wait streaming from RESET_PC
    cyc(1, 0, 0, 0, 0, 1, 32'h44, 1, 32'h40);
    cyc(1, 0, 0, 0, 0, 1, 32'h48, 1, 32'h44);
    cyc(1, 0, 0, 0, 0, 1, 32'h4C, 1, 32'h48);

    // Two wait states per fetch: two bubbles, address stable
    cyc(0, 0, 0, 0, 0, 1, 32'h4C, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h4C, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h50, 1, 32'h4C);
    cyc(0, 0, 0, 0, 0, 1, 32'h50, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h50, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h54, 1, 32'h50);

    // Load-use stall of 3 cycles while fetching 0x100
    cyc(1, 0, 0, 1, 32'hFC, 1, 32'hFC, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h100, 1, 32'hFC);
    cyc(1, 1, 1, 0, 0, 0, 32'h100, 1, 32'hFC);
    cyc(1, 1, 1, 0, 0, 0, 32'h100, 1, 32'hFC);
    cyc(1, 1, 1, 0, 0, 0, 32'h100, 1, 32'hFC);
    cyc(1, 0, 0, 0, 0, 1, 32'h104, 1, 32'h100);
    cyc(1, 0, 0, 0, 0, 1, 32'h108, 1, 32'h104);

    // Redirect to misaligned 0x203 during an outstanding fetch of 0x10
    cyc(1, 0, 0, 1, 32'h10, 1, 32'h10, 0, 0);
    cyc(0, 0, 0, 0, 0, 1, 32'h10, 0, 0);
    cyc(0, 0, 0, 1, 32'h203, 0, 32'h200, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 32'h200, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h200, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h204, 1, 32'h200);

    // Redirect while parked in HOLD with hold_ifid still high
    cyc(1, 1, 1, 0, 0, 0, 32'h204, 1, 32'h200);
    cyc(0, 1, 1, 1, 32'h300, 1, 32'h300, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h304, 1, 32'h300);

    // PC wrap-around, then hold_pc alone re-fetches the same address
    cyc(1, 0, 0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 0);
    cyc(1, 0, 0, 0, 0, 1, 32'h0, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 1, 32'h4, 1, 32'h0);
    cyc(1, 1, 0, 0, 0, 1, 32'h4, 1, 32'h4);
    cyc(1, 0, 0, 0, 0, 1, 32'h8, 1, 32'h4);

    // Asynchronous reset in the middle of a wait state, no clock edge in between
    imem_rdy = 1'b0; hold_pc = 1'b0; hold_ifid = 1'b0; branch_taken = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(1'b0, 32'h40, 1'b0, 32'd0, 32'd0, 1'b1);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 0, 0, 0, 0, 1, 32'h44, 1, 32'h40);

    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain_queue: got %0d unchecked expectations, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC register, issues requests to instruction memory over a req/rdy handshake, and drives the IF/ID pipeline register consumed by decode. It sits directly upstream of the hazard unit. It obeys that unit's load-use stall outputs, and branch redirects from ID/EX override the stall. Variable-latency memory responses, parked instructions during stalls, and killed in-flight fetches after redirects are all handled here.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset; low 2 bits must be 0
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- hold_pc  in  1  hazard stall: PC must not advance
- hold_ifid  in  1  hazard stall: IF/ID contents must not change
- branch_taken  in  1  redirect request; takes priority over holds
- branch_target  in  32  redirect address; bits [1:0] ignored and forced to 0
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address; equals PC
- imem_rdy  in  1  response valid; may be high in the same cycle as imem_req
- imem_rdata  in  32  instruction; sampled only when imem_req && imem_rdy
- IF_ID_Instr  out  32  decoded-stage instruction; 0 (NOP) on bubble
- IF_ID_PC4  out  32  PC+4 of IF_ID_Instr
- IF_ID_Valid  out  1  IF/ID holds a real instruction

## Operation
- Registered state: pc, park_instr, park_pc4, state ∈ {FETCH, HOLD, DRAIN}, IF/ID register.
- Reset (async, rst_n=0): pc=RESET_PC, state=FETCH, IF_ID_Instr=0, IF_ID_PC4=0, IF_ID_Valid=0, park registers=0. imem_req=0 while rst_n=0.
- FETCH: imem_req=1, imem_addr=pc; address is held stable until imem_rdy.
  - imem_rdy=1, hold_ifid=0: IF/ID <= {imem_rdata, pc+4, valid=1}. pc <= pc+4 unless hold_pc.
  - imem_rdy=1, hold_ifid=1: park_instr<=imem_rdata, park_pc4<=pc+4, state->HOLD; pc and IF/ID unchanged.
  - imem_rdy=0, hold_ifid=0: IF/ID <= bubble (Instr=0, Valid=0); pc unchanged.
  - imem_rdy=0, hold_ifid=1: IF/ID unchanged.
- HOLD: imem_req=0. When hold_ifid=0, IF/ID <= {park_instr, park_pc4, 1}, pc<=park_pc4 unless hold_pc, state->FETCH.
- Redirect (branch_taken=1, any state): pc <= {branch_target[31:2],2'b00}. IF/ID <= bubble, regardless of hold_ifid. Park contents are discarded.
  - State->DRAIN if a request is outstanding: FETCH with imem_rdy=0 that cycle. Otherwise state->FETCH.
- DRAIN: imem_req=0, imem_addr=pc. The first imem_rdy response is discarded, then state->FETCH. A further branch_taken in DRAIN updates pc and stays in DRAIN.
- PC arithmetic is modulo 2^32: pc=32'hFFFF_FFFC advances to 32'h0000_0000, and IF_ID_PC4 wraps identically.
- hold_pc=1 with hold_ifid=0 is legal. The instruction is delivered, but the same address is re-fetched next cycle.

## Timing
- Zero-wait memory (imem_rdy tied high): one instruction per cycle. IF_ID_Instr updates at the edge after pc is presented.
- Redirect latency: the branch_taken edge loads pc. The target's instruction appears in IF/ID no earlier than 1 cycle after that edge, or later with DRAIN and memory wait states.
- Load-use stall (holds high for N cycles): IF/ID and pc frozen for exactly N cycles. Stream resumes with no lost or duplicated instruction.
- Outputs are all registered except imem_req/imem_addr, which are functions of state and pc only, with no input-to-output combinational paths.
- rst_n asserted mid-request: imem_req drops immediately. The response is not tracked across reset.

## Test plan
- Reset, RESET_PC=32'h0000_0040, imem_rdy=1 -> imem_addr 0x40,0x44,0x48 on consecutive cycles; IF_ID_PC4 0x44,0x48,0x4C; IF_ID_Valid=1 from first edge.
- Memory with 2 wait cycles -> two bubbles (Instr=0, Valid=0) between each valid instruction; imem_addr stable throughout each wait.
- hold_pc=hold_ifid=1 for 3 cycles while fetching 0x100 -> IF/ID frozen 3 cycles; 0x100 instruction delivered after release, exactly once.
- branch_taken, target 0x203 (misaligned), during outstanding fetch of 0x10 -> IF/ID bubble, state DRAIN, stale 0x10 response dropped, next fetch at 0x200.
- branch_taken concurrent with hold_ifid=1 in HOLD -> redirect wins; parked instruction discarded; Valid=0.
- pc=32'hFFFF_FFFC, zero-wait -> next imem_addr=0x0, IF_ID_PC4=0x0; rst_n pulsed low mid-wait -> all outputs at reset values asynchronously.
